// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with RAW forwarding from EX/MEM and
//   load-use hazard detection that inserts a single bubble.
// Latency: one cycle ID->EX; stall_out is combinational in the same cycle.
// Backpressure: hold freezes every register; stall_out asks IF/ID to re-present.
// Ports: clk/reset; id_* instruction fields from ID; flush/hold pipeline control;
//   ex_result and mem_* forwarding sources; ex_* registered operands to the ALU;
//   stall_out hazard request; stall_count saturating count of load-use bubbles.
module ex_operand_stage #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [3:0]       id_ctrl,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [W-1:0]     id_rs_val,
  input  logic [W-1:0]     id_rt_val,
  input  logic [W-1:0]     id_imm,
  input  logic             id_use_imm,
  input  logic             id_shift_imm,
  input  logic [4:0]       id_shamt,
  input  logic [4:0]       id_dst,
  input  logic             id_wen,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic             hold,
  input  logic [W-1:0]     ex_result,
  input  logic             mem_wen,
  input  logic [4:0]       mem_dst,
  input  logic [W-1:0]     mem_result,
  output logic             stall_out,
  output logic             ex_valid,
  output logic [3:0]       ex_ctrl,
  output logic [W-1:0]     ex_op1,
  output logic [W-1:0]     ex_op2,
  output logic [4:0]       ex_dst,
  output logic             ex_wen,
  output logic             ex_is_load,
  output logic [W-1:0]     ex_store_data,
  output logic [CNT_W-1:0] stall_count
);

  logic             valid_q, valid_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [W-1:0]     op1_q, op1_d;
  logic [W-1:0]     op2_q, op2_d;
  logic [4:0]       dst_q, dst_d;
  logic             wen_q, wen_d;
  logic             load_q, load_d;
  logic [W-1:0]     sd_q, sd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [W-1:0]     fwd_rs, fwd_rt;

  // A load in EX has no result yet, so it is never an EX forwarding source;
  // that case is covered by the load-use stall instead.
  always_comb begin
    fwd_rs = id_rs_val;
    if (id_rs != 5'd0 && valid_q && wen_q && dst_q == id_rs && !load_q)
      fwd_rs = ex_result;
    else if (id_rs != 5'd0 && mem_wen && mem_dst == id_rs)
      fwd_rs = mem_result;
  end

  always_comb begin
    fwd_rt = id_rt_val;
    if (id_rt != 5'd0 && valid_q && wen_q && dst_q == id_rt && !load_q)
      fwd_rt = ex_result;
    else if (id_rt != 5'd0 && mem_wen && mem_dst == id_rt)
      fwd_rt = mem_result;
  end

  // Both source indices are compared even when the instruction ignores one.
  assign stall_out = id_valid && valid_q && load_q && wen_q && (dst_q != 5'd0) &&
                     (dst_q == id_rs || dst_q == id_rt) && !hold;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    dst_d   = dst_q;
    wen_d   = wen_q;
    load_d  = load_q;
    sd_d    = sd_q;
    cnt_d   = cnt_q;
    if (!hold) begin
      // Bubble unless a real instruction is captured below.
      valid_d = 1'b0;
      ctrl_d  = 4'd0;
      op1_d   = '0;
      op2_d   = '0;
      dst_d   = 5'd0;
      wen_d   = 1'b0;
      load_d  = 1'b0;
      sd_d    = '0;
      if (flush) begin
        cnt_d = cnt_q;
      end else if (stall_out) begin
        if (cnt_q != {CNT_W{1'b1}})
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (id_valid) begin
        valid_d = 1'b1;
        ctrl_d  = id_ctrl;
        dst_d   = id_dst;
        wen_d   = id_wen;
        load_d  = id_is_load;
        sd_d    = fwd_rt;
        if (id_shift_imm) begin
          op1_d = fwd_rt;
          op2_d = {{(W-5){1'b0}}, id_shamt};
        end else begin
          op1_d = fwd_rs;
          op2_d = id_use_imm ? id_imm : fwd_rt;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= 4'd0;
      op1_q   <= '0;
      op2_q   <= '0;
      dst_q   <= 5'd0;
      wen_q   <= 1'b0;
      load_q  <= 1'b0;
      sd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      dst_q   <= dst_d;
      wen_q   <= wen_d;
      load_q  <= load_d;
      sd_q    <= sd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_ctrl       = ctrl_q;
  assign ex_op1        = op1_q;
  assign ex_op2        = op2_q;
  assign ex_dst        = dst_q;
  assign ex_wen        = wen_q;
  assign ex_is_load    = load_q;
  assign ex_store_data = sd_q;
  assign stall_count   = cnt_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed scenarios followed by randomized traffic,
// all compared against a behavioural model of the EX stage contents.
module tb_ex_operand_stage;
  localparam int W     = 32;
  localparam int CNT_W = 3;   // narrow so counter saturation is reachable

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid;
  logic [3:0]       id_ctrl;
  logic [4:0]       id_rs, id_rt;
  logic [W-1:0]     id_rs_val, id_rt_val, id_imm;
  logic             id_use_imm, id_shift_imm;
  logic [4:0]       id_shamt, id_dst;
  logic             id_wen, id_is_load;
  logic             flush, hold;
  logic [W-1:0]     ex_result;
  logic             mem_wen;
  logic [4:0]       mem_dst;
  logic [W-1:0]     mem_result;
  logic             stall_out;
  logic             ex_valid;
  logic [3:0]       ex_ctrl;
  logic [W-1:0]     ex_op1, ex_op2;
  logic [4:0]       ex_dst;
  logic             ex_wen, ex_is_load;
  logic [W-1:0]     ex_store_data;
  logic [CNT_W-1:0] stall_count;

  ex_operand_stage #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_shift_imm(id_shift_imm),
    .id_shamt(id_shamt), .id_dst(id_dst), .id_wen(id_wen), .id_is_load(id_is_load),
    .flush(flush), .hold(hold), .ex_result(ex_result), .mem_wen(mem_wen),
    .mem_dst(mem_dst), .mem_result(mem_result), .stall_out(stall_out),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_dst(ex_dst), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
    .ex_store_data(ex_store_data), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        valid;
    bit [3:0]  ctrl;
    bit [31:0] op1, op2;
    bit [4:0]  dst;
    bit        wen, load;
    bit [31:0] sd;
    int        cnt;
  } ex_state_t;

  ex_state_t m;
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic ex_state_t bubble(input int cnt);
    ex_state_t b;
    b.valid = 0; b.ctrl = 0; b.op1 = 0; b.op2 = 0; b.dst = 0;
    b.wen = 0; b.load = 0; b.sd = 0; b.cnt = cnt;
    return b;
  endfunction

  // Value an instruction actually sees for source register s.
  function automatic bit [31:0] src_val(input bit [4:0] s, input bit [31:0] rf);
    if (s == 0) return rf;
    if (m.valid && m.wen && m.dst == s && !m.load) return ex_result;
    if (mem_wen && mem_dst == s) return mem_result;
    return rf;
  endfunction

  function automatic bit model_stall();
    return id_valid && !hold && m.valid && m.load && m.wen && m.dst != 0 &&
           (m.dst == id_rs || m.dst == id_rt);
  endfunction

  task automatic clr_in();
    id_valid = 0; id_ctrl = 0; id_rs = 0; id_rt = 0; id_rs_val = 0; id_rt_val = 0;
    id_imm = 0; id_use_imm = 0; id_shift_imm = 0; id_shamt = 0; id_dst = 0;
    id_wen = 0; id_is_load = 0; flush = 0; hold = 0; ex_result = 0;
    mem_wen = 0; mem_dst = 0; mem_result = 0;
  endtask

  // Inputs are already applied; check stall, advance model, clock, check outputs.
  task automatic step();
    bit        st;
    bit [31:0] rs_v, rt_v;
    ex_state_t n;
    #1;
    st = model_stall();
    if (!reset) chk("stall_out", 64'(stall_out), 64'(st));
    rs_v = src_val(id_rs, id_rs_val);
    rt_v = src_val(id_rt, id_rt_val);
    if (reset) n = bubble(0);
    else if (hold) n = m;
    else if (flush) n = bubble(m.cnt);
    else if (st) n = bubble(m.cnt == (1 << CNT_W) - 1 ? m.cnt : m.cnt + 1);
    else if (id_valid) begin
      n.valid = 1; n.ctrl = id_ctrl; n.dst = id_dst; n.wen = id_wen;
      n.load = id_is_load; n.sd = rt_v; n.cnt = m.cnt;
      n.op1 = id_shift_imm ? rt_v : rs_v;
      n.op2 = id_shift_imm ? 32'(id_shamt) : (id_use_imm ? id_imm : rt_v);
    end else n = bubble(m.cnt);
    @(posedge clk);
    m = n;
    #1;
    chk("ex_valid",  64'(ex_valid),      64'(m.valid));
    chk("ex_ctrl",   64'(ex_ctrl),       64'(m.ctrl));
    chk("ex_op1",    64'(ex_op1),        64'(m.op1));
    chk("ex_op2",    64'(ex_op2),        64'(m.op2));
    chk("ex_dst",    64'(ex_dst),        64'(m.dst));
    chk("ex_wen",    64'(ex_wen),        64'(m.wen));
    chk("ex_load",   64'(ex_is_load),    64'(m.load));
    chk("ex_sd",     64'(ex_store_data), 64'(m.sd));
    chk("stall_cnt", 64'(stall_count),   64'(m.cnt));
  endtask

  initial begin
    m = bubble(0);
    clr_in();
    // Reset for two cycles with a valid instruction presented.
    reset = 1; id_valid = 1; id_rs_val = 32'h55; id_rt_val = 32'h66;
    step(); step();
    chk("rst_valid", 64'(ex_valid), 64'd0);
    chk("rst_op1",   64'(ex_op1),   64'd0);
    chk("rst_cnt",   64'(stall_count), 64'd0);
    chk("rst_stall", 64'(stall_out), 64'd0);
    reset = 0;

    // Plain register operands.
    clr_in(); id_valid = 1; id_ctrl = 4'b0011; id_rs = 1; id_rt = 2;
    id_rs_val = 5; id_rt_val = 7; step();
    chk("basic_op1", 64'(ex_op1), 64'd5);
    chk("basic_op2", 64'(ex_op2), 64'd7);
    chk("basic_vld", 64'(ex_valid), 64'd1);

    // EX beats MEM.
    clr_in(); id_valid = 1; id_dst = 3; id_wen = 1; step();
    clr_in(); id_valid = 1; id_rs = 3; ex_result = 32'h10;
    mem_wen = 1; mem_dst = 3; mem_result = 32'h20; step();
    chk("ex_beats_mem", 64'(ex_op1), 64'h10);

    // Register 0 never forwards.
    clr_in(); id_valid = 1; id_dst = 0; id_wen = 1; step();
    clr_in(); id_valid = 1; id_rs = 0; ex_result = 32'hFF;
    mem_wen = 1; mem_dst = 0; mem_result = 32'hEE; step();
    chk("r0_nofwd", 64'(ex_op1), 64'd0);

    // Load-use: one bubble, then forward from MEM.
    clr_in(); id_valid = 1; id_dst = 4; id_wen = 1; id_is_load = 1; step();
    clr_in(); id_valid = 1; id_rs = 4; id_rs_val = 32'h1; step();
    chk("lu_bubble", 64'(ex_valid), 64'd0);
    chk("lu_cnt",    64'(stall_count), 64'd1);
    mem_wen = 1; mem_dst = 4; mem_result = 32'hAB; step();
    chk("lu_memfwd", 64'(ex_op1), 64'hAB);

    // Hold with flush and a pending hazard: frozen, then flush once released.
    clr_in(); id_valid = 1; id_dst = 6; id_wen = 1; id_is_load = 1; id_ctrl = 4'h9; step();
    clr_in(); id_valid = 1; id_rt = 6; hold = 1; flush = 1;
    for (int i = 0; i < 3; i++) step();
    chk("hold_vld", 64'(ex_valid), 64'd1);
    chk("hold_cnt", 64'(stall_count), 64'd1);
    hold = 0; step();
    chk("flush_vld", 64'(ex_valid), 64'd0);

    // Repeated load-use hazards drive the narrow counter into saturation.
    for (int i = 0; i < 10; i++) begin
      clr_in(); id_valid = 1; id_dst = 7; id_wen = 1; id_is_load = 1; step();
      clr_in(); id_valid = 1; id_rs = 7; step();
    end
    chk("cnt_sat", 64'(stall_count), 64'((1 << CNT_W) - 1));

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      clr_in();
      reset        = ($urandom_range(0, 99) == 0);
      id_valid     = ($urandom_range(0, 9) < 8);
      id_ctrl      = 4'($urandom);
      id_rs        = 5'($urandom_range(0, 4));
      id_rt        = 5'($urandom_range(0, 4));
      id_rs_val    = $urandom;
      id_rt_val    = $urandom;
      id_imm       = $urandom;
      id_use_imm   = ($urandom_range(0, 3) == 0);
      id_shift_imm = ($urandom_range(0, 4) == 0);
      id_shamt     = 5'($urandom);
      id_dst       = 5'($urandom_range(0, 4));
      id_wen       = ($urandom_range(0, 9) < 8);
      id_is_load   = ($urandom_range(0, 9) < 3);
      flush        = ($urandom_range(0, 9) == 0);
      hold         = ($urandom_range(0, 9) == 0);
      ex_result    = $urandom;
      mem_wen      = ($urandom_range(0, 1) == 1);
      mem_dst      = 5'($urandom_range(0, 4));
      mem_result   = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
